// File: rtl/gpio_port.sv
// Memory-mapped GPIO peripheral: output/direction registers, synchronised inputs and
// per-pin edge interrupts with write-1-to-clear pending bits; one-cycle registered reads.
module gpio_port #(
    parameter int WIDTH = 32,
    parameter int NGPIO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we_gpio,
    output logic [WIDTH-1:0] rdata_gpio,
    input  logic [NGPIO-1:0] gpio_i,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             irq
);

    logic [NGPIO-1:0] data_out_r;
    logic [NGPIO-1:0] dir_r;
    logic [NGPIO-1:0] irq_en_r;
    logic [NGPIO-1:0] edge_sel_r;
    logic [NGPIO-1:0] irq_pend_r;
    logic [NGPIO-1:0] s1_r;
    logic [NGPIO-1:0] s2_r;
    logic [NGPIO-1:0] s3_r;
    logic [1:0]       arm_cnt_r;
    logic [WIDTH-1:0] rdata_r;

    logic [WIDTH-1:0] rd_s;
    logic [NGPIO-1:0] rise_s;
    logic [NGPIO-1:0] fall_s;
    logic [NGPIO-1:0] edge_s;
    logic [NGPIO-1:0] w1c_s;
    logic [NGPIO-1:0] pend_next_s;
    logic             armed_s;
    logic             unused_bits_s;

    assign unused_bits_s = ^{addr[WIDTH-1:5], addr[1:0], wdata};

    // Read mux over the register map; unmapped offsets and upper bits read zero.
    always_comb begin
        rd_s = {WIDTH{1'b0}};
        case (addr[4:2])
            3'd0:    rd_s[NGPIO-1:0] = data_out_r;
            3'd1:    rd_s[NGPIO-1:0] = dir_r;
            3'd2:    rd_s[NGPIO-1:0] = s2_r;
            3'd3:    rd_s[NGPIO-1:0] = irq_en_r;
            3'd4:    rd_s[NGPIO-1:0] = edge_sel_r;
            3'd5:    rd_s[NGPIO-1:0] = irq_pend_r;
            default: rd_s = {WIDTH{1'b0}};
        endcase
    end

    // Edge detection is masked until the arm counter saturates, hiding pins high at reset.
    always_comb begin
        armed_s = (arm_cnt_r == 2'd3);
        rise_s  = s2_r & ~s3_r;
        fall_s  = ~s2_r & s3_r;
        edge_s  = (edge_sel_r & fall_s) | (~edge_sel_r & rise_s);
        if (we_gpio && (addr[4:2] == 3'd5)) begin
            w1c_s = wdata[NGPIO-1:0];
        end else begin
            w1c_s = {NGPIO{1'b0}};
        end
        pend_next_s = (irq_pend_r & ~w1c_s) | (edge_s & {NGPIO{armed_s}});
    end

    // Register file, synchroniser, arm counter and read-data pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= {NGPIO{1'b0}};
            dir_r      <= {NGPIO{1'b0}};
            irq_en_r   <= {NGPIO{1'b0}};
            edge_sel_r <= {NGPIO{1'b0}};
            irq_pend_r <= {NGPIO{1'b0}};
            s1_r       <= {NGPIO{1'b0}};
            s2_r       <= {NGPIO{1'b0}};
            s3_r       <= {NGPIO{1'b0}};
            arm_cnt_r  <= 2'd0;
            rdata_r    <= {WIDTH{1'b0}};
        end else begin
            if (we_gpio) begin
                case (addr[4:2])
                    3'd0:    data_out_r <= wdata[NGPIO-1:0];
                    3'd1:    dir_r      <= wdata[NGPIO-1:0];
                    3'd3:    irq_en_r   <= wdata[NGPIO-1:0];
                    3'd4:    edge_sel_r <= wdata[NGPIO-1:0];
                    default: ;
                endcase
            end
            s1_r       <= gpio_i;
            s2_r       <= s1_r;
            s3_r       <= s2_r;
            irq_pend_r <= pend_next_s;
            rdata_r    <= rd_s;
            if (!armed_s) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end
        end
    end

    assign rdata_gpio = rdata_r;
    assign gpio_o     = data_out_r;
    assign gpio_oe    = dir_r;
    assign irq        = |(irq_pend_r & irq_en_r);

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: read expectations are queued when the address is
// driven and compared when rdata_gpio becomes valid one cycle later.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we_gpio;
    logic [31:0] rdata_gpio;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    gpio_port #(.WIDTH(32), .NGPIO(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .wdata      (wdata),
        .we_gpio    (we_gpio),
        .rdata_gpio (rdata_gpio),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest queued read expectation and compare with the bus.
    task automatic sb_compare();
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, rdata_gpio, e);
        end
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] e, input string tag);
        @(negedge clk);
        addr    = {27'd0, off, 2'b00};
        we_gpio = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        sb_compare();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        addr    = {27'd0, off, 2'b00};
        wdata   = d;
        we_gpio = 1'b1;
        @(negedge clk);
        we_gpio = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        we_gpio = 1'b0;
        gpio_i  = 8'hFF;

        // Reset with all pins high
        idle(2);
        rst_n = 1'b1;
        check_val("rst_rdata", rdata_gpio, 32'd0);
        idle(10);
        check_val("rst_gpio_o", {24'd0, gpio_o}, 32'd0);
        check_val("rst_gpio_oe", {24'd0, gpio_oe}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        rd(3'd5, 32'h0, "rst_pend");
        rd(3'd2, 32'hFF, "rst_data_in");

        // Falls with rising-edge select set nothing
        gpio_i = 8'h04;
        idle(4);
        rd(3'd5, 32'h0, "fall_ignored_pend");

        // Output and direction registers
        wr(3'd0, 32'hA5);
        check_val("gpio_o", {24'd0, gpio_o}, 32'hA5);
        wr(3'd1, 32'h0F);
        check_val("gpio_oe", {24'd0, gpio_oe}, 32'h0F);
        rd(3'd0, 32'hA5, "rd_data_out");
        rd(3'd1, 32'h0F, "rd_dir");

        // Rising edge on pin 0, exactly three cycles to pending
        wr(3'd3, 32'h01);
        wr(3'd4, 32'h00);
        gpio_i = 8'h05;
        idle(2);
        check_val("rise_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        check_val("rise_irq", {31'd0, irq}, 32'd1);
        rd(3'd5, 32'h01, "rise_pend");
        wr(3'd5, 32'h01);
        check_val("rise_clr_irq", {31'd0, irq}, 32'd0);
        gpio_i = 8'h04;
        idle(5);
        rd(3'd5, 32'h0, "rise_fall_pend");

        // Falling edge on pin 2 and write-1-to-clear
        wr(3'd4, 32'h04);
        wr(3'd3, 32'h04);
        idle(3);
        rd(3'd5, 32'h0, "edgesel_no_pend");
        gpio_i = 8'h00;
        idle(4);
        rd(3'd5, 32'h04, "fall_pend");
        check_val("fall_irq", {31'd0, irq}, 32'd1);
        wr(3'd5, 32'h04);
        check_val("w1c_irq", {31'd0, irq}, 32'd0);
        rd(3'd5, 32'h0, "w1c_pend");

        // Clear of bit 1 on the same edge its rise is detected: set wins
        gpio_i = 8'h02;
        @(negedge clk);
        wr(3'd5, 32'h02);
        rd(3'd5, 32'h02, "collision_pend");
        check_val("collision_irq", {31'd0, irq}, 32'd0);

        // Unmapped offset, upper bits, read-only DATA_IN
        wr(3'd6, 32'hFFFFFFFF);
        wr(3'd0, 32'hFFFFFFFF);
        rd(3'd6, 32'h0, "unmapped");
        rd(3'd0, 32'hFF, "upper_bits");
        wr(3'd2, 32'hFFFFFFFF);
        rd(3'd2, 32'h02, "data_in_ro");

        // Read-before-write on the same edge
        @(negedge clk);
        addr    = 32'd0;
        wdata   = 32'h3C;
        we_gpio = 1'b1;
        exp_q.push_back(32'hFF);
        tag_q.push_back("rbw_old");
        @(negedge clk);
        we_gpio = 1'b0;
        sb_compare();
        rd(3'd0, 32'h3C, "rbw_new");

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
